// File: rtl/instr_controller.sv
// instr_controller: multi-cycle fetch/decode/execute/writeback sequencer driving a
// register file and functional unit from 16-bit instructions.
module instr_controller #(
   parameter int nBit  = 16,
   parameter int pcBit = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic             instr_req,
   input  logic             instr_ack,
   input  logic [nBit-1:0]  instr_data,
   output logic [pcBit-1:0] pc,
   output logic [2:0]       fs,
   output logic             a_thru,
   output logic             b_thru,
   output logic [nBit-1:0]  imm,
   output logic             imm_sel,
   output logic [2:0]       ra_addr,
   output logic [2:0]       rb_addr,
   output logic [2:0]       rd_addr,
   output logic             reg_we,
   input  logic             zero_flag,
   output logic             halted
);
   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

   state_t           state_q;
   logic [nBit-1:0]  ir_q;
   logic [pcBit-1:0] pc_q;
   logic             z_q;
   logic [2:0]       fs_q;
   logic             a_thru_q, b_thru_q, imm_sel_q, reg_we_q;
   logic [3:0]       op;
   logic             is_alu, is_ldi, is_mov, is_bz, is_jmp, is_halt, writes;

   assign op      = ir_q[nBit-1:nBit-4];
   assign is_alu  = ~op[3];
   assign is_ldi  = op == 4'b1000;
   assign is_mov  = op == 4'b1001;
   assign is_bz   = op == 4'b1010;
   assign is_jmp  = op == 4'b1011;
   assign is_halt = op == 4'b1111;
   assign writes  = is_alu | is_ldi | is_mov;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         ir_q <= '0;
         pc_q <= '0;
         z_q <= 1'b0;
         {fs_q, a_thru_q, b_thru_q, imm_sel_q, reg_we_q} <= '0;
      end else begin
         case (state_q)
            FETCH: if (instr_ack) begin
               ir_q <= instr_data;
               pc_q <= pc_q + 1'b1;
               state_q <= DECODE;
            end
            DECODE: begin
               fs_q <= is_alu ? op[2:0] : 3'd0;
               a_thru_q <= is_mov;
               b_thru_q <= is_ldi;
               imm_sel_q <= is_ldi;
               state_q <= EXECUTE;
            end
            EXECUTE: begin
               // writing ops keep their controls through WRITEBACK; others drop them here
               if (writes) begin
                  reg_we_q <= 1'b1;
                  state_q <= WRITEBACK;
               end else begin
                  {fs_q, a_thru_q, b_thru_q, imm_sel_q} <= '0;
                  state_q <= is_halt ? HALT : FETCH;
               end
               if (is_bz && z_q) pc_q <= pc_q + pcBit'({{pcBit{ir_q[7]}}, ir_q[7:0]});
               if (is_jmp) pc_q <= pcBit'(ir_q[7:0]);
            end
            WRITEBACK: begin
               {fs_q, a_thru_q, b_thru_q, imm_sel_q, reg_we_q} <= '0;
               z_q <= zero_flag;
               state_q <= FETCH;
            end
            HALT: state_q <= HALT;
            default: state_q <= FETCH;
         endcase
      end
   end

   assign instr_req = state_q == FETCH;
   assign halted    = state_q == HALT;
   assign pc        = pc_q;
   assign fs        = fs_q;
   assign a_thru    = a_thru_q;
   assign b_thru    = b_thru_q;
   assign imm_sel   = imm_sel_q;
   assign reg_we    = reg_we_q;
   assign imm       = {{(nBit-8){1'b0}}, ir_q[7:0]};
   assign rd_addr   = ir_q[11:9];
   assign ra_addr   = ir_q[8:6];
   assign rb_addr   = ir_q[5:3];
endmodule

// File: tb/tb_instr_controller.sv
// tb_instr_controller: directed scenario tests for instr_controller with
// hand-computed expectations; inputs driven and outputs sampled 1 time unit after posedge.
module tb_instr_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req;
   logic        instr_ack = 1'b0;
   logic [15:0] instr_data = '0;
   logic [7:0]  pc;
   logic [2:0]  fs;
   logic        a_thru, b_thru, imm_sel, reg_we, halted;
   logic [15:0] imm;
   logic [2:0]  ra_addr, rb_addr, rd_addr;
   logic        zero_flag = 1'b0;
   int          errors = 0;
   int          checks = 0;

   instr_controller #(.nBit(16), .pcBit(8)) dut (
      .clk(clk), .rst(rst), .instr_req(instr_req), .instr_ack(instr_ack),
      .instr_data(instr_data), .pc(pc), .fs(fs), .a_thru(a_thru), .b_thru(b_thru),
      .imm(imm), .imm_sel(imm_sel), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .rd_addr(rd_addr), .reg_we(reg_we), .zero_flag(zero_flag), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      instr_ack = 1'b0;
      zero_flag = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // waits (bounded) for FETCH, presents one instruction with ack; returns in DECODE
   task automatic issue(input logic [15:0] instr);
      for (int n = 0; n < 20 && !instr_req; n++) tick();
      checks++;
      if (instr_req !== 1'b1) begin errors++; $display("FAIL issue_wait: instr_req=%b want 1", instr_req); end
      instr_data = instr;
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks += 5;
      if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %0h want 0", pc); end
      if (instr_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", instr_req); end
      if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", reg_we); end
      if ({fs, a_thru, b_thru, imm_sel} !== 6'd0) begin errors++; $display("FAIL reset_ctl: got %0h want 0", {fs, a_thru, b_thru, imm_sel}); end
   endtask

   task automatic test_ldi;
      do_reset();
      issue(16'h8205);
      checks += 4;
      if (pc !== 8'h01) begin errors++; $display("FAIL ldi_pc: got %0h want 1", pc); end
      if (rd_addr !== 3'd1) begin errors++; $display("FAIL ldi_rd: got %0d want 1", rd_addr); end
      if (instr_req !== 1'b0) begin errors++; $display("FAIL ldi_dec_req: got %b want 0", instr_req); end
      if (b_thru !== 1'b0) begin errors++; $display("FAIL ldi_dec_bthru: got %b want 0", b_thru); end
      tick();
      checks += 5;
      if (b_thru !== 1'b1 || imm_sel !== 1'b1) begin errors++; $display("FAIL ldi_ex_ctl: b_thru=%b imm_sel=%b want 1 1", b_thru, imm_sel); end
      if (a_thru !== 1'b0) begin errors++; $display("FAIL ldi_ex_athru: got %b want 0", a_thru); end
      if (imm !== 16'h0005) begin errors++; $display("FAIL ldi_imm: got %0h want 5", imm); end
      if (reg_we !== 1'b0) begin errors++; $display("FAIL ldi_ex_we: got %b want 0", reg_we); end
      if (fs !== 3'd0) begin errors++; $display("FAIL ldi_fs: got %0d want 0", fs); end
      tick();
      checks += 3;
      if (reg_we !== 1'b1) begin errors++; $display("FAIL ldi_wb_we: got %b want 1", reg_we); end
      if (b_thru !== 1'b1 || imm_sel !== 1'b1) begin errors++; $display("FAIL ldi_wb_ctl: b_thru=%b imm_sel=%b want 1 1", b_thru, imm_sel); end
      if (rd_addr !== 3'd1) begin errors++; $display("FAIL ldi_wb_rd: got %0d want 1", rd_addr); end
      tick();
      checks += 3;
      if (reg_we !== 1'b0) begin errors++; $display("FAIL ldi_we_pulse: got %b want 0", reg_we); end
      if (instr_req !== 1'b1) begin errors++; $display("FAIL ldi_latency: instr_req=%b want 1", instr_req); end
      if (b_thru !== 1'b0 || imm_sel !== 1'b0) begin errors++; $display("FAIL ldi_clear: b_thru=%b imm_sel=%b want 0 0", b_thru, imm_sel); end
   endtask

   task automatic test_mov;
      do_reset();
      issue(16'h9240);
      checks += 2;
      if (ra_addr !== 3'd1) begin errors++; $display("FAIL mov_ra: got %0d want 1", ra_addr); end
      if (rd_addr !== 3'd1) begin errors++; $display("FAIL mov_rd: got %0d want 1", rd_addr); end
      tick();
      checks += 2;
      if (a_thru !== 1'b1 || b_thru !== 1'b0) begin errors++; $display("FAIL mov_thru: a=%b b=%b want 1 0", a_thru, b_thru); end
      if (imm_sel !== 1'b0) begin errors++; $display("FAIL mov_imm_sel: got %b want 0", imm_sel); end
      tick();
      checks++;
      if (reg_we !== 1'b1 || a_thru !== 1'b1) begin errors++; $display("FAIL mov_wb: we=%b a=%b want 1 1", reg_we, a_thru); end
   endtask

   // ALU op then BZ -2: branch taken when Z=1, not taken when Z=0
   task automatic test_branch(input logic z, input logic [7:0] want_pc);
      do_reset();
      issue(16'h6458);
      checks += 2;
      if (rb_addr !== 3'd3) begin errors++; $display("FAIL alu_rb: got %0d want 3", rb_addr); end
      if (fs !== 3'd0) begin errors++; $display("FAIL alu_dec_fs: got %0d want 0", fs); end
      tick();
      checks++;
      if (fs !== 3'd6) begin errors++; $display("FAIL alu_ex_fs: got %0d want 6", fs); end
      tick();
      zero_flag = z;
      checks++;
      if (reg_we !== 1'b1 || fs !== 3'd6) begin errors++; $display("FAIL alu_wb: we=%b fs=%0d want 1 6", reg_we, fs); end
      tick();
      zero_flag = 1'b0;
      issue(16'hA0FE);
      checks++;
      if (pc !== 8'h02) begin errors++; $display("FAIL bz_pc_inc: got %0h want 2", pc); end
      tick();
      checks++;
      if (fs !== 3'd0 || reg_we !== 1'b0) begin errors++; $display("FAIL bz_ex_ctl: fs=%0d we=%b want 0 0", fs, reg_we); end
      tick();
      checks += 2;
      if (pc !== want_pc) begin errors++; $display("FAIL bz_z%0d_pc: got %0h want %0h", z, pc, want_pc); end
      if (instr_req !== 1'b1) begin errors++; $display("FAIL bz_latency: instr_req=%b want 1", instr_req); end
   endtask

   task automatic test_stall;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (instr_req !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL stall_%0d: req=%b pc=%0h want 1 0", i, instr_req, pc); end
      end
      issue(16'hC000);
      instr_data = 16'hF000;
      instr_ack = 1'b1;
      tick();
      tick();
      instr_ack = 1'b0;
      checks += 2;
      if (pc !== 8'h01) begin errors++; $display("FAIL ack_ignored_pc: got %0h want 1", pc); end
      if (halted !== 1'b0 || instr_req !== 1'b1) begin errors++; $display("FAIL ack_ignored_state: halted=%b req=%b want 0 1", halted, instr_req); end
   endtask

   task automatic test_jmp_wrap;
      do_reset();
      issue(16'hB0FF);
      tick();
      tick();
      checks++;
      if (pc !== 8'hFF) begin errors++; $display("FAIL jmp_pc: got %0h want ff", pc); end
      issue(16'hC000);
      checks++;
      if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %0h want 0", pc); end
      tick();
      checks++;
      if (reg_we !== 1'b0) begin errors++; $display("FAIL nop_we: got %b want 0", reg_we); end
      tick();
      checks++;
      if (pc !== 8'h00 || instr_req !== 1'b1) begin errors++; $display("FAIL nop_end: pc=%0h req=%b want 0 1", pc, instr_req); end
   endtask

   task automatic test_halt;
      do_reset();
      issue(16'hF000);
      tick();
      tick();
      instr_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (halted !== 1'b1 || instr_req !== 1'b0 || pc !== 8'h01) begin errors++; $display("FAIL halt_%0d: halted=%b req=%b pc=%0h want 1 0 1", i, halted, instr_req, pc); end
         tick();
      end
      instr_ack = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (halted !== 1'b0 || instr_req !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL halt_reset: halted=%b req=%b pc=%0h want 0 1 0", halted, instr_req, pc); end
   endtask

   task automatic test_reset_in_wb;
      do_reset();
      issue(16'h0200);
      tick();
      tick();
      zero_flag = 1'b1;
      tick();
      issue(16'h0400);
      tick();
      tick();
      checks++;
      if (reg_we !== 1'b1) begin errors++; $display("FAIL wb_reach: we=%b want 1", reg_we); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      zero_flag = 1'b0;
      checks += 2;
      if (reg_we !== 1'b0) begin errors++; $display("FAIL wb_reset_we: got %b want 0", reg_we); end
      if (pc !== 8'h00 || instr_req !== 1'b1) begin errors++; $display("FAIL wb_reset_pc: pc=%0h req=%b want 0 1", pc, instr_req); end
      issue(16'hA005);
      tick();
      tick();
      checks++;
      if (pc !== 8'h01) begin errors++; $display("FAIL wb_reset_z: pc=%0h want 1", pc); end
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_mov();
      test_branch(1'b1, 8'h00);
      test_branch(1'b0, 8'h02);
      test_stall();
      test_jmp_wrap();
      test_halt();
      test_reset_in_wb();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
